// File: rtl/led_scan_if.sv
// Bundle between the frame producer and the LED matrix scanner.
//   enable      : 1 = scan, 0 = matrix dark
//   leds        : ROWS*COLS frame, index = row*COLS + col
//   frame_valid : 1-cycle strobe, leds holds a new frame
//   row_out     : one-hot row select, active-high
//   col_out     : column drive for the selected row
//   frame_done  : 1-cycle pulse at the end of the last row
//   db_row      : current row index
//   db_state    : FSM state code (IDLE=0, BLANK=1, DRIVE=2)
// master = producer/board side, slave = scanner.
interface led_scan_if #(
    parameter int ROWS = 6,
    parameter int COLS = 6
);
    logic                   enable;
    logic [ROWS*COLS-1:0]   leds;
    logic                   frame_valid;
    logic [ROWS-1:0]        row_out;
    logic [COLS-1:0]        col_out;
    logic                   frame_done;
    logic [2:0]             db_row;
    logic [1:0]             db_state;

    modport master (
        output enable, leds, frame_valid,
        input  row_out, col_out, frame_done, db_row, db_state
    );

    modport slave (
        input  enable, leds, frame_valid,
        output row_out, col_out, frame_done, db_row, db_state
    );
endinterface

// File: rtl/led_matrix_scan.sv
// Row-multiplexed LED matrix scanner with double-buffered frames.
// Each row is preceded by BLANK dark cycles and then driven for DWELL cycles.
// New frames land in a pending buffer and are copied to the displayed buffer
// only at a frame boundary, so a frame never tears.
// Ports:
//   clock     : system clock
//   restart_n : synchronous reset, active-low
//   bus       : led_scan_if slave (enable/leds/frame_valid in,
//               row_out/col_out/frame_done/db_row/db_state out)
module led_matrix_scan #(
    parameter int ROWS        = 6,
    parameter int COLS        = 6,
    parameter int DWELL       = 50000,
    parameter int BLANK       = 500,
    parameter int COL_ACT_LOW = 1
) (
    input  logic       clock,
    input  logic       restart_n,
    led_scan_if.slave  bus
);
    localparam int N       = ROWS * COLS;
    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [COLS-1:0] COL_OFF = (COL_ACT_LOW != 0) ? {COLS{1'b1}} : {COLS{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         row_q, row_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               frame_end;
    logic [N-1:0]       pending_q, active_q;
    logic               pend_full_q;
    logic [ROWS-1:0]    row_out_q, row_out_d;
    logic [COLS-1:0]    col_out_q, col_out_d;
    logic               frame_done_q;

    // Column pattern of one row of a frame, in pin polarity.
    function automatic logic [COLS-1:0] row_cols(input logic [N-1:0] frame, input logic [2:0] r);
        logic [N-1:0] sh;
        sh = frame >> (COLS * int'(r));
        return (COL_ACT_LOW != 0) ? ~sh[COLS-1:0] : sh[COLS-1:0];
    endfunction

    // Next-state decision: counters reload to 0 on every state entry.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        frame_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    state_d = S_BLANK;
                    row_d   = 3'd0;
                    cnt_d   = '0;
                end
            end
            S_BLANK: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                    row_d   = 3'd0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(BLANK - 1)) begin
                    state_d = S_DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRIVE: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                    row_d   = 3'd0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(DWELL - 1)) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    if (row_q == 3'(ROWS - 1)) begin
                        row_d     = 3'd0;
                        frame_end = 1'b1;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                row_d   = 3'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin values follow the next state so they line up with db_state/db_row.
    // The displayed buffer only changes when entering BLANK, so using the
    // current active_q for a DRIVE row is safe.
    always_comb begin
        row_out_d = '0;
        col_out_d = COL_OFF;
        if (state_d == S_DRIVE) begin
            row_out_d = ROWS'(1) << row_d;
            col_out_d = row_cols(active_q, row_d);
        end
    end

    always_ff @(posedge clock) begin
        if (!restart_n) begin
            state_q      <= S_IDLE;
            row_q        <= 3'd0;
            cnt_q        <= '0;
            pending_q    <= '0;
            active_q     <= '0;
            pend_full_q  <= 1'b0;
            row_out_q    <= '0;
            col_out_q    <= COL_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            cnt_q        <= cnt_d;
            row_out_q    <= row_out_d;
            col_out_q    <= col_out_d;
            frame_done_q <= frame_end;
            // At a frame boundary a simultaneous strobe bypasses pending.
            if (frame_end) begin
                if (bus.frame_valid) begin
                    active_q    <= bus.leds;
                    pend_full_q <= 1'b0;
                end else if (pend_full_q) begin
                    active_q    <= pending_q;
                    pend_full_q <= 1'b0;
                end
            end else if (bus.frame_valid) begin
                pending_q   <= bus.leds;
                pend_full_q <= 1'b1;
            end
        end
    end

    assign bus.row_out    = row_out_q;
    assign bus.col_out    = col_out_q;
    assign bus.frame_done = frame_done_q;
    assign bus.db_row     = row_q;
    assign bus.db_state   = state_q;
endmodule
